// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - shared APB widths, responder state encoding and defaults
package uart_apb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] UNMAPPED_DEFAULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/apb_reg_responder.sv
// rtl/apb_reg_responder.sv - APB completer with a zeroed word bank, programmable wait states
// and a saturating count of accesses outside the mapped window.
module apb_reg_responder
  import uart_apb_pkg::*;
#(
  parameter logic [15:0]       BASE_HI       = 16'h0123,
  parameter int                AW            = 4,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = UNMAPPED_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  input  logic [3:0]        wait_cfg,
  output logic              busy,
  output logic [7:0]        err_count
);

  state_t            state;
  state_t            state_nxt;
  logic              penable_q;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_write;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] bank [2**AW];

  logic              accept;
  logic              enter_resp;
  logic [ADDR_W-1:0] use_addr;
  logic              use_write;
  logic [DATA_W-1:0] use_wdata;
  logic              mapped;
  logic [AW-1:0]     idx;
  logic              unused_addr_bits;

  assign accept = (state == ST_IDLE) && penable && !penable_q;

  // A zero-wait transfer commits on its acceptance edge, before the capture
  // registers are loaded, so the live bus values are used in that case.
  assign use_addr  = (state == ST_IDLE) ? paddr  : cap_addr;
  assign use_write = (state == ST_IDLE) ? pwrite : cap_write;
  assign use_wdata = (state == ST_IDLE) ? pwdata : cap_wdata;

  assign mapped = (use_addr[31:16] == BASE_HI);
  assign idx    = use_addr[AW+1:2];
  assign unused_addr_bits = ^{use_addr[15:AW+2], use_addr[1:0]};

  assign pready = (state == ST_RESP);
  assign busy   = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (wait_cfg == 4'd0) begin
            state_nxt  = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt == 4'd1) begin
          state_nxt  = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      penable_q <= 1'b0;
      wcnt      <= 4'd0;
      cap_addr  <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      prdata    <= '0;
      err_count <= 8'd0;
      for (int i = 0; i < 2**AW; i++) begin
        bank[i] <= '0;
      end
    end else begin
      state     <= state_nxt;
      penable_q <= penable;

      if (accept) begin
        wcnt      <= wait_cfg;
        cap_addr  <= paddr;
        cap_write <= pwrite;
        cap_wdata <= pwdata;
      end else if (state == ST_WAIT) begin
        wcnt <= wcnt - 4'd1;
      end

      if (enter_resp) begin
        if (mapped) begin
          if (use_write) begin
            bank[idx] <= use_wdata;
          end else begin
            prdata <= bank[idx];
          end
        end else begin
          if (!use_write) begin
            prdata <= UNMAPPED_DATA;
          end
          if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_responder.sv
// tb/tb_apb_reg_responder.sv - directed scoreboard bench for apb_reg_responder
module tb_apb_reg_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] paddr;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic [3:0]  wait_cfg;
  logic        busy;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  apb_reg_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .paddr     (paddr),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .wait_cfg  (wait_cfg),
    .busy      (busy),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mbank [16];
  logic [31:0] mlast;
  int          merr;
  int          checks;
  int          failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mbank[i] = 32'h0;
    mlast = 32'h0;
    merr  = 0;
    sbq.delete();
  endtask

  // One transfer; inputs are scrambled while it is in flight. With hold=1
  // penable stays high for 10 cycles after pready.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] wcfg, input logic hold);
    exp_t e;
    int   lat;
    int   busyc;
    int   extra;
    bit   done;
    if (addr[31:16] == 16'h0123) begin
      if (wr) mbank[addr[5:2]] = wd;
      else    mlast = mbank[addr[5:2]];
    end else begin
      if (!wr) mlast = 32'hDEADBEEF;
      if (merr < 255) merr++;
    end
    e.data = mlast;
    e.err  = merr[7:0];
    sbq.push_back(e);

    @(negedge clk);
    paddr = addr; pwrite = wr; pwdata = wd; wait_cfg = wcfg; penable = 1'b1;
    lat = 0; busyc = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (busy) busyc++;
      paddr = ~addr; pwdata = ~wd; pwrite = ~wr; wait_cfg = ~wcfg;
      if (pready) begin
        done = 1;
        e = sbq.pop_front();
        check("prdata", prdata, e.data);
        check("err_count", {24'h0, err_count}, {24'h0, e.err});
      end
    end
    check("pready_seen", {31'h0, done}, 32'd1);
    if (done) begin
      check("latency", lat, wcfg + 1);
      check("busy_cycles", busyc, wcfg + 1);
    end else begin
      void'(sbq.pop_front());
    end
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (pready || busy) extra++;
      end
      check("hold_no_retrigger", extra, 0);
    end
    penable = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    model_reset();
    reset_n = 1'b0; paddr = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0; wait_cfg = '0;
    repeat (3) @(negedge clk);
    check("rst_pready", {31'h0, pready}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_err", {24'h0, err_count}, 32'h0);
    reset_n = 1'b1;

    xfer(32'h01234564, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'h01234567, 1'b1, 32'h89ABCDEF, 4'd0, 1'b0);
    xfer(32'h01234564, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'h01234568, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'hFEDCBA01, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'hFEDCBA01, 1'b1, 32'h55555555, 4'd1, 1'b0);
    xfer(32'h01234564, 1'b0, 32'h0, 4'd2, 1'b0);
    xfer(32'h012300A4, 1'b0, 32'h0, 4'd3, 1'b0);
    xfer(32'h0123FFE8, 1'b1, 32'hCAFEF00D, 4'd15, 1'b0);
    xfer(32'h01234528, 1'b0, 32'h0, 4'd15, 1'b0);
    xfer(32'h01234514, 1'b1, 32'h11111111, 4'd2, 1'b1);
    xfer(32'h01234514, 1'b0, 32'h0, 4'd0, 1'b1);

    for (int n = 0; n < 256; n++) begin
      xfer({16'hA5A5 ^ n[15:0], n[15:0]}, n[0], $urandom, 4'($urandom_range(0, 2)), 1'b0);
    end
    check("err_saturated", {24'h0, err_count}, 32'd255);

    @(negedge clk);
    paddr = 32'h01234508; pwrite = 1'b1; pwdata = 32'h12345678; wait_cfg = 4'd8; penable = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_busy", {31'h0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pready", {31'h0, pready}, 32'd0);
    check("mid_rst_busy", {31'h0, busy}, 32'd0);
    check("mid_rst_err", {24'h0, err_count}, 32'h0);
    check("mid_rst_prdata", prdata, 32'h0);
    model_reset();
    penable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xfer(32'h01234508, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'h01234524, 1'b0, 32'h0, 4'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_reg_responder.md
Name: apb_reg_responder

Overview:
- APB completer that sits on the far end of the uart_apb bridge's APB initiator port.
- Serves reads and writes to a small zero-initialised word register bank, with a per-transfer programmable wait-state count.
- Counts accesses that fall outside its mapped window.
- Used as the standard target for bridge bring-up and regression benches; port set matches the bridge exactly (no psel, no pslverr).

Parameters:
- BASE_HI, 16'h0123, required value of paddr[31:16] for a mapped access
- AW, 4, word-index width; bank depth is 2**AW 32-bit words
- UNMAPPED_DATA, 32'hDEADBEEF, prdata returned for unmapped reads

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- paddr  in  32  byte address, held by the initiator until pready
- penable  in  1  transfer request / access phase, held until pready
- pwrite  in  1  1 = write, 0 = read, held with paddr
- pwdata  in  32  write data, held with paddr
- prdata  out  32  read data, valid while pready=1
- pready  out  1  one-cycle completion pulse
- wait_cfg  in  4  extra wait states, sampled at acceptance
- busy  out  1  high from acceptance through the pready cycle
- err_count  out  8  saturating count of unmapped accesses

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Values on reset: state IDLE, pready=0, busy=0, prdata=0, err_count=0, all bank words=0, penable_q=0.
- Acceptance: only on a penable rising edge, i.e. penable=1 and registered penable_q=0.
  - penable held high past pready never triggers a second transfer.
  - When accepted, capture paddr, pwrite, pwdata and wait_cfg; set busy=1.
- Decode:
  - mapped = (paddr[31:16]==BASE_HI).
  - Word index = paddr[AW+1:2]; paddr[1:0] ignored; bits above the index within the low half are ignored (aliasing).
- FSM has three states: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: on acceptance, load wcnt=wait_cfg. Go to RESP if wait_cfg==0, else go to WAIT.
  - WAIT: decrement wcnt each cycle. When wcnt==1, go to RESP.
  - RESP (one cycle): pready=1 and busy=1. Next state is always IDLE.
- Latency: with acceptance sampled at edge E0, pready is high in the cycle after edge E0+wait_cfg. wait_cfg=0 gives pready in the cycle right after E0; wait_cfg=15 adds 15 cycles.
- Commit on the edge entering RESP:
  - Mapped write: bank[idx] <= pwdata.
  - Mapped read: prdata <= bank[idx].
  - Unmapped read: prdata <= UNMAPPED_DATA.
  - Unmapped write: dropped; prdata is unchanged.
  - Any unmapped access: err_count += 1, saturating at 255.
- prdata holds its value outside RESP until the next read commit. Writes do not change prdata.
- A read immediately after a write to the same index returns the new data.
- Inputs changing during WAIT are ignored; the values captured at acceptance are used.
- penable dropping before pready (a protocol violation) does not abort the transfer; it completes normally.
- Reset asserted mid-transfer: the FSM immediately returns to IDLE with pready=0 and the bank cleared. No write is committed.
- Back-to-back transfers: the initiator's penable low cycle after pready re-arms acceptance, so at most one transfer is in flight.

Decomposition:
- uart_apb_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - UNMAPPED_DATA default
  - APB width constants (ADDR_W=32, DATA_W=32)
- No sub-module. The wait counter and the bank stay inline in a single module of about 150-200 lines.

Test Plan:
- Reset, then read paddr=32'h01234564 with wait_cfg=0 -> pready in the cycle after acceptance, prdata=32'h0, err_count=0.
- Write paddr=32'h01234567, pwdata=32'h89ABCDEF (index 9), then read 32'h01234564 -> prdata=32'h89ABCDEF; read 32'h01234568 (index 10) -> 32'h0.
- Read paddr=32'hFEDCBA01 -> prdata=32'hDEADBEEF, err_count=1. Then write to 32'hFEDCBA01 -> bank unchanged, err_count=2. 256 further unmapped accesses -> err_count=255.
- wait_cfg=3 -> pready exactly 4 cycles after acceptance and busy high for 4 cycles. wait_cfg=15 -> 16 cycles.
- Hold penable=1 for 10 cycles after pready -> exactly one pready pulse and no second write or err_count increment.
- Assert reset_n=0 during WAIT of a write to index 2 -> pready stays 0, busy=0. A later read of index 2 returns 32'h0.
